// File: rtl/kernel_dupn.sv
// kernel_dupn: one producer port fanned out to OUTPUTS consumer ports.
// Every output has its own DEPTH-entry queue, so one stalled consumer
// only holds up the others once its own queue is full.
// MODE_RR=0 sends every token to all outputs (broadcast).
// MODE_RR=1 sends each token to one output, in strict cyclic order.
module kernel_dupn #(
   parameter int WIDTH   = 16,
   parameter int OUTPUTS = 3,
   parameter int DEPTH   = 2,
   parameter int MODE_RR = 0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         input_S1,
   input  logic                     avail_S1,
   output logic                     read_S1,
   output logic [OUTPUTS*WIDTH-1:0] output_data,
   output logic [OUTPUTS-1:0]       write,
   input  logic [OUTPUTS-1:0]       full,
   output logic                     running
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);
   localparam int TW = $clog2(OUTPUTS);

   logic [WIDTH-1:0] mem_q [OUTPUTS][DEPTH];
   logic [WIDTH-1:0] mem_d [OUTPUTS][DEPTH];
   logic [CW-1:0]    cnt_q [OUTPUTS];
   logic [CW-1:0]    cnt_d [OUTPUTS];
   logic [PW-1:0]    rd_q  [OUTPUTS];
   logic [PW-1:0]    rd_d  [OUTPUTS];
   logic [PW-1:0]    wr_q  [OUTPUTS];
   logic [PW-1:0]    wr_d  [OUTPUTS];
   logic [TW-1:0]    tgt_q;
   logic [TW-1:0]    tgt_d;
   logic             running_q;
   logic             running_d;

   logic [OUTPUTS-1:0] space;
   logic [OUTPUTS-1:0] push;
   logic [OUTPUTS-1:0] pop;
   logic               tgt_space;
   logic               any_pending;

   // Handshake decode: space comes from registered counts only, so full
   // never reaches read_S1 combinationally.
   always_comb begin
      space     = '0;
      push      = '0;
      pop       = '0;
      tgt_space = 1'b0;
      for (int i = 0; i < OUTPUTS; i++) begin
         space[i] = (cnt_q[i] != CW'(DEPTH));
         if (tgt_q == TW'(i)) tgt_space = space[i];
      end
      if (MODE_RR != 0) read_S1 = avail_S1 & tgt_space & ~rst;
      else              read_S1 = avail_S1 & (&space) & ~rst;
      for (int i = 0; i < OUTPUTS; i++) begin
         push[i] = read_S1 & ((MODE_RR == 0) | (tgt_q == TW'(i)));
         pop[i]  = ~rst & (cnt_q[i] != '0) & ~full[i];
      end
      write = pop;
   end

   // Queue heads presented on the packed output bus.
   always_comb begin
      output_data = '0;
      for (int i = 0; i < OUTPUTS; i++)
         output_data[i*WIDTH +: WIDTH] = mem_q[i][rd_q[i]];
   end

   // Next-state for storage, pointers, counts, target and activity flag.
   always_comb begin
      mem_d       = mem_q;
      cnt_d       = cnt_q;
      rd_d        = rd_q;
      wr_d        = wr_q;
      tgt_d       = tgt_q;
      any_pending = 1'b0;
      for (int i = 0; i < OUTPUTS; i++) begin
         if (cnt_q[i] != '0) any_pending = 1'b1;
         if (push[i]) begin
            mem_d[i][wr_q[i]] = input_S1;
            wr_d[i]           = wr_q[i] + PW'(1);
         end
         if (pop[i]) rd_d[i] = rd_q[i] + PW'(1);
         if (push[i] && !pop[i])      cnt_d[i] = cnt_q[i] + CW'(1);
         else if (pop[i] && !push[i]) cnt_d[i] = cnt_q[i] - CW'(1);
      end
      if ((MODE_RR != 0) && read_S1) begin
         if (tgt_q == TW'(OUTPUTS - 1)) tgt_d = '0;
         else                           tgt_d = tgt_q + TW'(1);
      end
      running_d = avail_S1 | any_pending;
   end

   // State registers; reset discards all queued tokens and zeroes storage.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < OUTPUTS; i++) begin
            for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
            cnt_q[i] <= '0;
            rd_q[i]  <= '0;
            wr_q[i]  <= '0;
         end
         tgt_q     <= '0;
         running_q <= 1'b1;
      end else begin
         mem_q     <= mem_d;
         cnt_q     <= cnt_d;
         rd_q      <= rd_d;
         wr_q      <= wr_d;
         tgt_q     <= tgt_d;
         running_q <= running_d;
      end
   end

   assign running = running_q;

endmodule

// File: tb/tb_kernel_dupn.sv
// Bench for kernel_dupn: a broadcast instance (index 0) and a round-robin
// instance (index 1) run side by side against a queue-level model.
module tb_kernel_dupn;

   localparam int W = 16;
   localparam int N = 3;
   localparam int D = 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [1:0][W-1:0]   din;
   logic [1:0]          avail;
   logic [1:0]          rd;
   logic [1:0][N*W-1:0] od;
   logic [1:0][N-1:0]   wr;
   logic [1:0][N-1:0]   fl;
   logic [1:0]          run;

   kernel_dupn #(.WIDTH(W), .OUTPUTS(N), .DEPTH(D), .MODE_RR(0)) u_bc (
      .clk(clk), .rst(rst), .input_S1(din[0]), .avail_S1(avail[0]),
      .read_S1(rd[0]), .output_data(od[0]), .write(wr[0]), .full(fl[0]),
      .running(run[0]));

   kernel_dupn #(.WIDTH(W), .OUTPUTS(N), .DEPTH(D), .MODE_RR(1)) u_rr (
      .clk(clk), .rst(rst), .input_S1(din[1]), .avail_S1(avail[1]),
      .read_S1(rd[1]), .output_data(od[1]), .write(wr[1]), .full(fl[1]),
      .running(run[1]));

   int errors = 0;
   int checks = 0;

   // Reference model: per-output token queues, a cyclic target index,
   // the expected running flag and the producer's pending token list.
   logic [W-1:0] mq  [2][N][$];
   logic [W-1:0] src [2][$];
   int           tgt [2];
   bit           run_exp [2];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int i = 0; i < N; i++) mq[d][i].delete();
         tgt[d]     = 0;
         run_exp[d] = 1'b1;
      end
   endtask

   // One clock: drive inputs, check outputs at negedge, advance the model
   // at the posedge with the same inputs the DUT sampled.
   task automatic cycle(input bit g0, input bit g1);
      bit gate [2];
      bit exp_rd [2];
      bit exp_w [2][N];
      bit pend;
      gate[0] = g0;
      gate[1] = g1;
      for (int d = 0; d < 2; d++) begin
         avail[d] = gate[d] && (src[d].size() > 0);
         din[d]   = (src[d].size() > 0) ? src[d][0] : '0;
      end
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         bit sp;
         if (d == 0) begin
            sp = 1'b1;
            for (int i = 0; i < N; i++) if (mq[d][i].size() >= D) sp = 1'b0;
         end else begin
            sp = mq[d][tgt[d]].size() < D;
         end
         exp_rd[d] = !rst && avail[d] && sp;
         chk($sformatf("read_S1[%0d]", d), 64'(rd[d]), 64'(exp_rd[d]));
         for (int i = 0; i < N; i++) begin
            exp_w[d][i] = !rst && (mq[d][i].size() != 0) && !fl[d][i];
            chk($sformatf("write[%0d][%0d]", d, i), 64'(wr[d][i]), 64'(exp_w[d][i]));
            if (exp_w[d][i])
               chk($sformatf("data[%0d][%0d]", d, i), 64'(od[d][i*W +: W]), 64'(mq[d][i][0]));
         end
         chk($sformatf("running[%0d]", d), 64'(run[d]), 64'(run_exp[d]));
      end
      @(posedge clk);
      if (rst) begin
         model_reset();
      end else begin
         for (int d = 0; d < 2; d++) begin
            pend = 1'b0;
            for (int i = 0; i < N; i++) if (mq[d][i].size() != 0) pend = 1'b1;
            run_exp[d] = avail[d] || pend;
            for (int i = 0; i < N; i++) if (exp_w[d][i]) void'(mq[d][i].pop_front());
            if (exp_rd[d]) begin
               if (d == 0) begin
                  for (int i = 0; i < N; i++) mq[d][i].push_back(src[d][0]);
               end else begin
                  mq[d][tgt[d]].push_back(src[d][0]);
                  tgt[d] = (tgt[d] + 1) % N;
               end
               void'(src[d].pop_front());
            end
         end
      end
      #1;
   endtask

   initial begin
      rst   = 1'b1;
      fl    = '0;
      avail = '0;
      din   = '0;
      model_reset();
      #1;
      cycle(1, 1);
      cycle(1, 1);
      chk("od_reset[0]", 64'(od[0]), 64'd0);
      chk("od_reset[1]", 64'(od[1]), 64'd0);
      rst = 1'b0;

      // Broadcast stream 1..4 with all consumers ready.
      for (int k = 1; k <= 4; k++) src[0].push_back(W'(k));
      for (int c = 0; c < 6; c++) cycle(1, 1);

      // Broadcast slow consumer on channel 1.
      for (int k = 'h10; k <= 'h15; k++) src[0].push_back(W'(k));
      fl[0] = 3'b010;
      for (int c = 0; c < 6; c++) cycle(1, 1);
      chk("bc_stall_pending", 64'(src[0].size()), 64'd4);
      fl[0] = 3'b000;
      for (int c = 0; c < 10; c++) cycle(1, 1);

      // Round-robin A..D, then eight tokens with channel 1 held full.
      src[1].push_back(16'h000A);
      src[1].push_back(16'h000B);
      src[1].push_back(16'h000C);
      src[1].push_back(16'h000D);
      for (int c = 0; c < 6; c++) cycle(1, 1);
      chk("rr_tgt_after_4", 64'(tgt[1]), 64'd1);
      fl[1] = 3'b010;
      for (int k = 0; k < 8; k++) src[1].push_back(16'h0100 + W'(k));
      for (int c = 0; c < 10; c++) cycle(1, 1);
      chk("rr_stall_ch1_depth", 64'(mq[1][1].size()), 64'd2);
      fl[1] = 3'b000;
      for (int c = 0; c < 12; c++) cycle(1, 1);

      // Fill both instances (2 tokens per channel), then reset mid-stream.
      fl = '{3'b111, 3'b111};
      for (int k = 0; k < 8; k++) begin
         src[0].push_back(16'h0200 + W'(k));
         src[1].push_back(16'h0300 + W'(k));
      end
      for (int c = 0; c < 8; c++) cycle(1, 1);
      chk("pre_reset_fill_bc", 64'(mq[0][2].size()), 64'd2);
      chk("pre_reset_fill_rr", 64'(mq[1][2].size()), 64'd2);
      fl  = '0;
      rst = 1'b1;
      cycle(1, 1);
      chk("od_after_rst[0]", 64'(od[0]), 64'd0);
      chk("od_after_rst[1]", 64'(od[1]), 64'd0);
      rst = 1'b0;
      for (int c = 0; c < 8; c++) cycle(1, 1);

      // Idle detection: drain, then raise avail again.
      src[0].delete();
      src[1].delete();
      for (int c = 0; c < 5; c++) cycle(1, 1);
      chk("idle_bc", 64'(run[0]), 64'd0);
      chk("idle_rr", 64'(run[1]), 64'd0);
      src[0].push_back(16'h0BEE);
      src[1].push_back(16'h0CAF);
      cycle(1, 1);
      cycle(1, 1);
      chk("wake_bc", 64'(run[0]), 64'd1);
      chk("wake_rr", 64'(run[1]), 64'd1);

      // Randomized traffic: random gaps, backpressure and occasional reset.
      for (int c = 0; c < 400; c++) begin
         for (int d = 0; d < 2; d++) begin
            if (src[d].size() < 3) src[d].push_back(W'($urandom));
            fl[d] = N'($urandom_range(0, 7) & $urandom_range(0, 7));
         end
         rst = ($urandom_range(0, 99) == 0);
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      end
      rst = 1'b0;
      fl  = '0;
      src[0].delete();
      src[1].delete();
      for (int c = 0; c < 6; c++) cycle(1, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
